// File: rtl/word_sched_rr_32_8_if.sv
// word_sched_rr_32_8_if: requester/demux-side signals of the round-robin word scheduler
interface word_sched_rr_32_8_if;
  logic [31:0] req0_data;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req1_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        grant_id;
  logic [1:0]  phase;
  modport master (
    output req0_data, req0_valid, req1_data, req1_valid,
    input  req0_ready, req1_ready, word_out, word_valid, grant_id, phase
  );
  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid,
    output req0_ready, req1_ready, word_out, word_valid, grant_id, phase
  );
endinterface

// File: rtl/word_sched_rr_32_8.sv
// word_sched_rr_32_8: two-requester round-robin word scheduler feeding a 32->8 byte demux
module word_sched_rr_32_8 #(
  parameter int MAX_BURST = 4
) (
  input logic                   clk_4f,
  input logic                   reset,
  word_sched_rr_32_8_if.slave   bus
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      state_q;
  logic [1:0]  phase_q;
  logic [31:0] word_q;
  logic        valid_q;
  logic        gid_q;
  logic        last_q;
  logic [3:0]  burst_q;
  logic [3:0]  burst_d;
  logic        load, own_v, oth_v, keep, win, restart, xfer;
  // A zero burst count means no burst is running, so the requester other than
  // last is preferred; with last=1 out of reset this gives req0 the first grant.
  always_comb begin
    load    = (state_q == IDLE) || (phase_q == 2'd3);
    own_v   = last_q ? bus.req1_valid : bus.req0_valid;
    oth_v   = last_q ? bus.req0_valid : bus.req1_valid;
    keep    = own_v && (burst_q != 4'd0) && (burst_q < 4'(MAX_BURST));
    win     = (keep || !oth_v) ? last_q : !last_q;
    restart = !keep && !oth_v;
    xfer    = reset && load && (own_v || oth_v);
    burst_d = (restart || (win != last_q)) ? 4'd1 :
              (burst_q == 4'(MAX_BURST)) ? burst_q : burst_q + 4'd1;
  end
  assign bus.req0_ready = xfer && !win;
  assign bus.req1_ready = xfer && win;
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.grant_id   = gid_q;
  assign bus.phase      = phase_q;
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= 4'd0;
    end else if (xfer) begin
      state_q <= SEND;
      phase_q <= 2'd0;
      word_q  <= win ? bus.req1_data : bus.req0_data;
      valid_q <= 1'b1;
      gid_q   <= win;
      last_q  <= win;
      burst_q <= burst_d;
    end else if (state_q == SEND) begin
      if (phase_q != 2'd3) begin
        phase_q <= phase_q + 2'd1;
      end else begin
        state_q <= IDLE;
        phase_q <= 2'd0;
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_word_sched_rr_32_8.sv
// tb_word_sched_rr_32_8: directed self-checking bench for the round-robin word scheduler
module tb_word_sched_rr_32_8;
  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  int passed = 0;
  int total  = 0;
  word_sched_rr_32_8_if bus();
  word_sched_rr_32_8 #(.MAX_BURST(4)) dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));
  always #5 clk_4f = ~clk_4f;
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask
  task automatic start();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data = 32'd0;
    bus.req1_data = 32'd0;
    tick();
    reset = 1'b1;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data = 32'h01010101;
    bus.req1_data = 32'h02020202;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.word_valid} !== 3'b000)
        $display("FAIL reset_hold%0d: ready0/ready1/valid=%b required 000", i,
                 {bus.req0_ready, bus.req1_ready, bus.word_valid});
      else passed++;
    end
    total++;
    if ({bus.word_out, bus.grant_id, bus.phase} !== 35'd0)
      $display("FAIL reset_values: word=%h gid=%b phase=%0d required 0", bus.word_out, bus.grant_id, bus.phase);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL reset_first_grant_ready: %b required 10", {bus.req0_ready, bus.req1_ready});
    else passed++;
    tick();
    total++;
    if (bus.word_valid !== 1'b1 || bus.grant_id !== 1'b0 || bus.word_out !== 32'h01010101)
      $display("FAIL reset_first_word: valid=%b gid=%b word=%h required 1 0 01010101",
               bus.word_valid, bus.grant_id, bus.word_out);
    else passed++;
  endtask
  task automatic test_back_to_back();
    logic [31:0] ew;
    start();
    bus.req0_valid = 1'b1;
    bus.req0_data = 32'hA1B2C3D4;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1) $display("FAIL b2b_ready_idle: %b required 1", bus.req0_ready);
    else passed++;
    tick();
    for (int i = 0; i < 8; i++) begin
      ew = (i < 4) ? 32'hA1B2C3D4 : 32'h11223344;
      total++;
      if (bus.word_valid !== 1'b1 || bus.phase !== 2'(i % 4) || bus.word_out !== ew)
        $display("FAIL b2b_cycle%0d: valid=%b phase=%0d word=%h required 1 %0d %h",
                 i, bus.word_valid, bus.phase, bus.word_out, i % 4, ew);
      else passed++;
      total++;
      if (bus.req0_ready !== (i % 4 == 3 && i < 7))
        $display("FAIL b2b_ready%0d: %b required %b", i, bus.req0_ready, (i % 4 == 3 && i < 7));
      else passed++;
      if (i == 3) bus.req0_data = 32'h11223344;
      if (i == 6) bus.req0_valid = 1'b0;
      if (i != 3) #0;
      tick();
    end
    total++;
    if (bus.word_valid !== 1'b0 || bus.phase !== 2'd0)
      $display("FAIL b2b_end: valid=%b phase=%0d required 0 0", bus.word_valid, bus.phase);
    else passed++;
  endtask
  task automatic test_burst();
    logic [9:0] pat = 10'b0011110000;
    logic eg;
    start();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data = 32'h000000A0;
    bus.req1_data = 32'h000000B1;
    #1;
    for (int w = 0; w < 10; w++) begin
      eg = pat[w];
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== {!eg, eg})
        $display("FAIL burst_ready_w%0d: %b required %b", w, {bus.req0_ready, bus.req1_ready}, {!eg, eg});
      else passed++;
      tick();
      total++;
      if (bus.grant_id !== eg || bus.word_out !== (eg ? 32'h000000B1 : 32'h000000A0))
        $display("FAIL burst_grant_w%0d: gid=%b word=%h required %b", w, bus.grant_id, bus.word_out, eg);
      else passed++;
      for (int p = 0; p < 3; p++) begin
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
          $display("FAIL burst_midword_ready_w%0d_p%0d: %b required 00", w, p, {bus.req0_ready, bus.req1_ready});
        else passed++;
        tick();
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask
  task automatic test_idle_grant();
    bit fell = 1'b0;
    start();
    bus.req0_valid = 1'b1;
    bus.req0_data = 32'h0BADF00D;
    tick();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 10 && !fell; i++) begin
      tick();
      fell = (bus.word_valid == 1'b0);
    end
    total++;
    if (!fell) $display("FAIL idle_fall: word_valid never fell within 10 cycles");
    else passed++;
    bus.req1_valid = 1'b1;
    bus.req1_data = 32'hCAFEF00D;
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      $display("FAIL idle_ready: %b required 01", {bus.req0_ready, bus.req1_ready});
    else passed++;
    tick();
    bus.req1_valid = 1'b0;
    total++;
    if (bus.word_valid !== 1'b1 || bus.phase !== 2'd0 || bus.grant_id !== 1'b1 || bus.word_out !== 32'hCAFEF00D)
      $display("FAIL idle_grant: valid=%b phase=%0d gid=%b word=%h required 1 0 1 cafef00d",
               bus.word_valid, bus.phase, bus.grant_id, bus.word_out);
    else passed++;
  endtask
  task automatic test_reset_mid();
    start();
    bus.req0_valid = 1'b1;
    bus.req0_data = 32'h55AA55AA;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    total++;
    if (bus.phase !== 2'd2 || bus.word_out !== 32'h55AA55AA)
      $display("FAIL midrst_pre: phase=%0d word=%h required 2 55aa55aa", bus.phase, bus.word_out);
    else passed++;
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data = 32'h12345678;
    bus.req1_data = 32'h87654321;
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      $display("FAIL midrst_ready_in_reset: %b required 00", {bus.req0_ready, bus.req1_ready});
    else passed++;
    tick();
    total++;
    if (bus.word_valid !== 1'b0 || bus.phase !== 2'd0 || bus.word_out !== 32'd0)
      $display("FAIL midrst_abort: valid=%b phase=%0d word=%h required 0 0 0", bus.word_valid, bus.phase, bus.word_out);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL midrst_priority: %b required 10", {bus.req0_ready, bus.req1_ready});
    else passed++;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    total++;
    if (bus.word_out !== 32'h12345678 || bus.phase !== 2'd0 || bus.grant_id !== 1'b0)
      $display("FAIL midrst_restart: word=%h phase=%0d gid=%b required 12345678 0 0", bus.word_out, bus.phase, bus.grant_id);
    else passed++;
  endtask
  task automatic test_data_freeze();
    logic [31:0] junk [3] = '{32'h13579BDF, 32'h2468ACE0, 32'hFFFF0000};
    start();
    bus.req0_valid = 1'b1;
    bus.req0_data = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.req0_data = junk[i];
      tick();
      total++;
      if (bus.word_out !== 32'hDEADBEEF || bus.phase !== 2'(i + 1))
        $display("FAIL freeze_p%0d: word=%h phase=%0d required deadbeef %0d", i + 1, bus.word_out, bus.phase, i + 1);
      else passed++;
    end
    bus.req0_valid = 1'b0;
    tick();
    total++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 32'hDEADBEEF)
      $display("FAIL freeze_idle: valid=%b word=%h required 0 deadbeef", bus.word_valid, bus.word_out);
    else passed++;
  endtask
  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data = 32'd0;
    bus.req1_data = 32'd0;
    test_reset();
    test_back_to_back();
    test_burst();
    test_idle_grant();
    test_reset_mid();
    test_data_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
